can_feature_extractor: RTL and testbench

Converts a beat-oriented stream of received CAN frames into one parallel feature record per completed frame: arbitration ID, DLC, first and last data byte, byte sum, and inter-frame time delta in microseconds. It sits directly upstream of `feature_scaler`. Its outputs map one-to-one onto that stage's `arb_id_dec`/`data_length`/`first_byte`/`last_byte`/`byte_sum`/`time_delta`/`valid_in` inputs.

---
 rtl/can_feature_extractor.sv | 232 +++++++++++++++++++++++
 tb/tb_can_feature_extractor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/can_feature_extractor.sv
// CAN frame beat stream to per-frame feature record (ID, DLC, first/last byte, sum, time delta).
// Optional inter-beat timeout in DATA is built when CAN_FEAT_TIMEOUT_EN is defined.
module can_feature_extractor #(
  parameter int unsigned CLK_PER_US  = 50,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frm_valid,
  output logic        frm_ready,
  input  logic        frm_sof,
  input  logic [10:0] frm_id,
  input  logic [3:0]  frm_dlc,
  input  logic [7:0]  frm_data,
  output logic [10:0] arb_id_dec,
  output logic [3:0]  data_length,
  output logic [7:0]  first_byte,
  output logic [7:0]  last_byte,
  output logic [10:0] byte_sum,
  output logic [31:0] time_delta,
  output logic        valid_out,
  output logic [7:0]  err_cnt
);

  localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, EMIT = 2'd2} state_t;

  state_t        state_r;
  logic          frm_ready_r;
  logic [PW-1:0] presc_r;
  logic [31:0]   us_cnt_r;
  logic [31:0]   hdr_ts_r;
  logic [31:0]   last_ts_r;
  logic          first_flag_r;
  logic [10:0]   id_r;
  logic [3:0]    dlc_eff_r;
  logic [3:0]    idx_r;
  logic [10:0]   sum_r;
  logic [7:0]    first_r;
  logic [7:0]    last_r;
  logic [10:0]   arb_id_r;
  logic [3:0]    dlen_r;
  logic [7:0]    fb_r;
  logic [7:0]    lb_r;
  logic [10:0]   bsum_r;
  logic [31:0]   delta_r;
  logic          valid_r;
  logic [7:0]    err_r;

  logic          us_tick_s;
  logic          accept_s;
  logic          hdr_acc_s;
  logic          dat_acc_s;
  logic [3:0]    dlc_in_s;
  logic [10:0]   sum_nx_s;
  logic [7:0]    first_nx_s;
  logic          last_beat_s;
  logic [31:0]   delta_hdr_s;
  logic [31:0]   delta_dat_s;
  logic          err_evt_s;
  logic          timeout_s;

  assign us_tick_s = (presc_r == PW'(CLK_PER_US - 1));
  assign accept_s  = frm_valid & frm_ready_r;
  assign hdr_acc_s = accept_s & frm_sof;
  assign dat_acc_s = accept_s & ~frm_sof;

  // Next-value helpers for the datapath and the error event
  always_comb begin
    dlc_in_s    = frm_dlc;
    sum_nx_s    = sum_r + {3'd0, frm_data};
    first_nx_s  = first_r;
    last_beat_s = (idx_r == (dlc_eff_r - 4'd1));
    delta_hdr_s = us_cnt_r - last_ts_r;
    delta_dat_s = hdr_ts_r - last_ts_r;
    err_evt_s   = 1'b0;
    if (frm_dlc > 4'd8) begin
      dlc_in_s = 4'd8;
    end else begin
      dlc_in_s = frm_dlc;
    end
    if (idx_r == 4'd0) begin
      first_nx_s = frm_data;
    end else begin
      first_nx_s = first_r;
    end
    // The first emitted frame after reset has no predecessor to measure against
    if (first_flag_r) begin
      delta_hdr_s = 32'd0;
      delta_dat_s = 32'd0;
    end else begin
      delta_hdr_s = us_cnt_r - last_ts_r;
      delta_dat_s = hdr_ts_r - last_ts_r;
    end
    if ((hdr_acc_s && state_r == DATA) || (dat_acc_s && state_r == IDLE) || timeout_s) begin
      err_evt_s = 1'b1;
    end else begin
      err_evt_s = 1'b0;
    end
  end

`ifdef CAN_FEAT_TIMEOUT_EN
  logic [31:0] to_cnt_r;

  // Counts DATA cycles without an accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_r <= 32'd0;
    end else if (state_r != DATA || accept_s) begin
      to_cnt_r <= 32'd0;
    end else begin
      to_cnt_r <= to_cnt_r + 32'd1;
    end
  end

  assign timeout_s = (state_r == DATA) && !accept_s && (to_cnt_r == 32'(TIMEOUT_CYC - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Microsecond prescaler and free-running wrapping timestamp
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r  <= '0;
      us_cnt_r <= 32'd0;
    end else if (us_tick_s) begin
      presc_r  <= '0;
      us_cnt_r <= us_cnt_r + 32'd1;
    end else begin
      presc_r  <= presc_r + PW'(1);
      us_cnt_r <= us_cnt_r;
    end
  end

  // Frame FSM, accumulation and registered feature outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      frm_ready_r  <= 1'b1;
      hdr_ts_r     <= 32'd0;
      last_ts_r    <= 32'd0;
      first_flag_r <= 1'b1;
      id_r         <= 11'd0;
      dlc_eff_r    <= 4'd0;
      idx_r        <= 4'd0;
      sum_r        <= 11'd0;
      first_r      <= 8'd0;
      last_r       <= 8'd0;
      arb_id_r     <= 11'd0;
      dlen_r       <= 4'd0;
      fb_r         <= 8'd0;
      lb_r         <= 8'd0;
      bsum_r       <= 11'd0;
      delta_r      <= 32'd0;
      valid_r      <= 1'b0;
      err_r        <= 8'd0;
    end else begin
      valid_r <= 1'b0;
      if (err_evt_s && err_r != 8'd255) begin
        err_r <= err_r + 8'd1;
      end
      case (state_r)
        IDLE, DATA: begin
          if (hdr_acc_s) begin
            id_r      <= frm_id;
            dlc_eff_r <= dlc_in_s;
            hdr_ts_r  <= us_cnt_r;
            sum_r     <= 11'd0;
            first_r   <= 8'd0;
            last_r    <= 8'd0;
            idx_r     <= 4'd0;
            if (dlc_in_s == 4'd0) begin
              state_r     <= EMIT;
              frm_ready_r <= 1'b0;
              valid_r     <= 1'b1;
              arb_id_r    <= frm_id;
              dlen_r      <= 4'd0;
              fb_r        <= 8'd0;
              lb_r        <= 8'd0;
              bsum_r      <= 11'd0;
              delta_r     <= delta_hdr_s;
            end else begin
              state_r     <= DATA;
              frm_ready_r <= 1'b1;
            end
          end else if (state_r == DATA && dat_acc_s) begin
            sum_r   <= sum_nx_s;
            first_r <= first_nx_s;
            last_r  <= frm_data;
            idx_r   <= idx_r + 4'd1;
            if (last_beat_s) begin
              state_r     <= EMIT;
              frm_ready_r <= 1'b0;
              valid_r     <= 1'b1;
              arb_id_r    <= id_r;
              dlen_r      <= dlc_eff_r;
              fb_r        <= first_nx_s;
              lb_r        <= frm_data;
              bsum_r      <= sum_nx_s;
              delta_r     <= delta_dat_s;
            end
          end else if (timeout_s) begin
            state_r     <= IDLE;
            frm_ready_r <= 1'b1;
          end
        end
        EMIT: begin
          last_ts_r    <= hdr_ts_r;
          first_flag_r <= 1'b0;
          state_r      <= IDLE;
          frm_ready_r  <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          frm_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign frm_ready   = frm_ready_r;
  assign arb_id_dec  = arb_id_r;
  assign data_length = dlen_r;
  assign first_byte  = fb_r;
  assign last_byte   = lb_r;
  assign byte_sum    = bsum_r;
  assign time_delta  = delta_r;
  assign valid_out   = valid_r;
  assign err_cnt     = err_r;

endmodule

// File: tb/tb_can_feature_extractor.sv
// Scoreboard bench for can_feature_extractor: expected feature records are queued as frames
// are driven and compared when valid_out pulses.
module tb_can_feature_extractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frm_valid = 1'b0;
  logic        frm_ready;
  logic        frm_sof = 1'b0;
  logic [10:0] frm_id = 11'd0;
  logic [3:0]  frm_dlc = 4'd0;
  logic [7:0]  frm_data = 8'd0;
  logic [10:0] arb_id_dec;
  logic [3:0]  data_length;
  logic [7:0]  first_byte;
  logic [7:0]  last_byte;
  logic [10:0] byte_sum;
  logic [31:0] time_delta;
  logic        valid_out;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  can_feature_extractor #(.CLK_PER_US(1), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .frm_valid(frm_valid), .frm_ready(frm_ready),
    .frm_sof(frm_sof), .frm_id(frm_id), .frm_dlc(frm_dlc), .frm_data(frm_data),
    .arb_id_dec(arb_id_dec), .data_length(data_length), .first_byte(first_byte),
    .last_byte(last_byte), .byte_sum(byte_sum), .time_delta(time_delta),
    .valid_out(valid_out), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [7:0]  fb;
    logic [7:0]  lb;
    logic [10:0] sum;
    logic [31:0] delta;
  } feat_t;

  feat_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  exp_err = 8'd0;
  logic [31:0] tb_us = 32'd0;
  logic        tb_first = 1'b1;
  logic [31:0] tb_last_ts = 32'd0;
  logic [31:0] force_val = 32'd0;
  logic [7:0]  dat [8];
  logic [31:0] ts_a;
  logic [31:0] ts_b;
  logic [31:0] ts_tmp;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Microsecond timebase model (one tick per cycle at CLK_PER_US=1)
  always @(posedge clk) tb_us <= rst ? 32'd0 : tb_us + 32'd1;

  // Output monitor and scoreboard comparison
  always @(negedge clk) begin
    feat_t e;
    check_val("ready_only_low_in_emit", {31'd0, frm_ready}, {31'd0, ~valid_out});
    if (valid_out) begin
      check_val("pending_expect", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("arb_id_dec", 32'(arb_id_dec), 32'(e.id));
        check_val("data_length", 32'(data_length), 32'(e.dlc));
        check_val("first_byte", 32'(first_byte), 32'(e.fb));
        check_val("last_byte", 32'(last_byte), 32'(e.lb));
        check_val("byte_sum", 32'(byte_sum), 32'(e.sum));
        check_val("time_delta", time_delta, e.delta);
      end
    end
  end

  task automatic beat(input logic sof, input logic [10:0] id, input logic [3:0] dlc,
                      input logic [7:0] d, output logic [31:0] ts);
    @(negedge clk);
    frm_valid = 1'b1; frm_sof = sof; frm_id = id; frm_dlc = dlc; frm_data = d;
    for (int k = 0; k < 50 && !frm_ready; k++) @(negedge clk);
    if (!frm_ready) check_val("beat_accept_timeout", {31'd0, frm_ready}, 32'd1);
    ts = tb_us;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    frm_valid = 1'b0;
    frm_sof = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [10:0] id, input logic [3:0] dlc,
                            input logic fts, input logic [31:0] fval, output logic [31:0] ts);
    feat_t e;
    logic [31:0] dummy;
    int n;
    n = (dlc > 4'd8) ? 8 : int'(dlc);
    if (fts) begin
      force_val = fval;
      force dut.us_cnt_r = force_val;
    end
    beat(1'b1, id, dlc, 8'd0, ts);
    if (fts) begin
      release dut.us_cnt_r;
      ts = fval;
    end
    e.id = id; e.dlc = 4'(n); e.fb = 8'd0; e.lb = 8'd0; e.sum = 11'd0;
    for (int i = 0; i < n; i++) begin
      beat(1'b0, 11'd0, 4'd0, dat[i], dummy);
      e.sum = e.sum + {3'd0, dat[i]};
      if (i == 0) e.fb = dat[i];
      e.lb = dat[i];
    end
    e.delta = tb_first ? 32'd0 : ts - tb_last_ts;
    tb_first = 1'b0;
    tb_last_ts = ts;
    exp_q.push_back(e);
  endtask

  task automatic wait_until_us(input logic [31:0] target);
    for (int k = 0; k < 1000 && tb_us != target - 32'd1; k++) @(negedge clk);
    if (tb_us != target - 32'd1) check_val("wait_us_timeout", tb_us, target - 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    check_val({tag, "_ready"}, {31'd0, frm_ready}, 32'd1);
    check_val({tag, "_id"}, 32'(arb_id_dec), 32'd0);
    check_val({tag, "_dlc"}, 32'(data_length), 32'd0);
    check_val({tag, "_sum"}, 32'(byte_sum), 32'd0);
    check_val({tag, "_fb_lb"}, {16'd0, first_byte, last_byte}, 32'd0);
    check_val({tag, "_delta"}, time_delta, 32'd0);
    check_val({tag, "_err"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset");

    // Basic 4-byte frame, first after reset
    dat = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(11'h123, 4'd4, 1'b0, 32'd0, ts_a);
    idle(3);

    // DLC=0 frame exactly 100 us after the previous header
    wait_until_us(ts_a + 32'd100);
    send_frame(11'h7FF, 4'd0, 1'b0, 32'd0, ts_b);
    idle(3);

    // DLC clamp plus a stray ninth beat
    dat = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_frame(11'h2A5, 4'd15, 1'b0, 32'd0, ts_tmp);
    beat(1'b0, 11'd0, 4'd0, 8'hFF, ts_tmp);
    exp_err = exp_err + 8'd1;
    idle(2);
    check_val("err_after_stray", 32'(err_cnt), 32'(exp_err));

    // Header interrupting a partial frame
    beat(1'b1, 11'h300, 4'd8, 8'd0, ts_tmp);
    dat = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) beat(1'b0, 11'd0, 4'd0, dat[i], ts_tmp);
    exp_err = exp_err + 8'd1;
    dat = '{8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(11'h055, 4'd1, 1'b0, 32'd0, ts_tmp);
    idle(2);
    check_val("err_after_abort", 32'(err_cnt), 32'(exp_err));

    // Timestamp wrap between consecutive headers
    send_frame(11'h111, 4'd0, 1'b1, 32'hFFFF_FFF0, ts_tmp);
    idle(2);
    send_frame(11'h222, 4'd0, 1'b1, 32'h0000_0010, ts_tmp);
    idle(2);

    // Reset in the middle of a frame
    beat(1'b1, 11'h0AB, 4'd2, 8'd0, ts_tmp);
    beat(1'b0, 11'd0, 4'd0, 8'h5A, ts_tmp);
    @(negedge clk);
    frm_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 8'd0;
    tb_first = 1'b1;
    @(negedge clk);
    check_zero_outputs("mid_rst");

    // Long gap inside DATA
    beat(1'b1, 11'h0CD, 4'd2, 8'd0, ts_a);
    beat(1'b0, 11'd0, 4'd0, 8'h11, ts_tmp);
    idle(40);
`ifdef CAN_FEAT_TIMEOUT_EN
    exp_err = exp_err + 8'd1;
    check_val("err_after_timeout", 32'(err_cnt), 32'(exp_err));
    beat(1'b0, 11'd0, 4'd0, 8'h22, ts_tmp);
    exp_err = exp_err + 8'd1;
`else
    check_val("err_no_timeout", 32'(err_cnt), 32'(exp_err));
    exp_q.push_back('{id: 11'h0CD, dlc: 4'd2, fb: 8'h11, lb: 8'h22, sum: 11'h033, delta: 32'd0});
    tb_first = 1'b0;
    beat(1'b0, 11'd0, 4'd0, 8'h22, ts_tmp);
`endif
    idle(3);
    check_val("err_final", 32'(err_cnt), 32'(exp_err));
    check_val("leftover_expect", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
